cpu_dmem_responder: RTL and testbench

- Responder for the five-stage CPU's data-memory port. Decodes wr_mem/mem_addr/dout from the CPU's MEM stage and returns read data on din in the same cycle.
- Contains a word-addressed data RAM plus three memory-mapped registers:
  - a TX FIFO that drains to an external valid/ready stream;
  - a FIFO status/overflow register;
  - a free-running cycle counter.
- Sits beside the CPU at top level; replaces the external memory model.

---
 rtl/cpu_dmem_responder.sv | 114 +++++++++++
 tb/tb_cpu_dmem_responder.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/cpu_dmem_responder.sv
// Data-memory responder for the five-stage CPU. It answers reads combinationally in the same cycle.
// The word RAM sits at bit18=0. The TX FIFO, FIFO status and cycle counter are mapped at 0x40000.
module cpu_dmem_responder #(
    parameter int RAM_AW  = 10,
    parameter int FIFO_AW = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_mem,
    input  logic [18:0] mem_addr,
    input  logic [31:0] dout,
    output logic [31:0] din,
    output logic [31:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);
    localparam int RAM_WORDS  = 1 << RAM_AW;
    localparam int FIFO_DEPTH = 1 << FIFO_AW;

    // Register word addresses, compared against mem_addr[18:2].
    localparam logic [16:0] WA_TXDATA = 17'h10000;
    localparam logic [16:0] WA_STATUS = 17'h10001;
    localparam logic [16:0] WA_CYCLE  = 17'h10002;

    typedef logic [FIFO_AW-1:0] ptr_t;
    typedef logic [FIFO_AW:0]   cnt_t;

    localparam ptr_t PTR_ONE  = ptr_t'(1);
    localparam cnt_t CNT_ONE  = cnt_t'(1);
    localparam cnt_t CNT_FULL = cnt_t'(FIFO_DEPTH);

    logic [31:0] ram_q  [0:RAM_WORDS-1]  = '{default: '0};
    logic [31:0] fifo_q [0:FIFO_DEPTH-1] = '{default: '0};

    ptr_t        wptr_q, wptr_d;
    ptr_t        rptr_q, rptr_d;
    cnt_t        count_q, count_d;
    logic        ovf_q, ovf_d;
    logic [31:0] cycle_q, cycle_d;

    logic [RAM_AW-1:0] ram_idx;
    logic              sel_ram, sel_tx, sel_status, sel_cycle;
    logic              ram_we, push_req, status_we, cycle_we;
    logic              pop, push_ok, drop, full, empty;
    logic              unused_addr;

    assign ram_idx     = mem_addr[RAM_AW+1:2];
    assign sel_ram     = ~mem_addr[18];
    assign sel_tx      = (mem_addr[18:2] == WA_TXDATA);
    assign sel_status  = (mem_addr[18:2] == WA_STATUS);
    assign sel_cycle   = (mem_addr[18:2] == WA_CYCLE);
    assign unused_addr = ^mem_addr[1:0];

    assign ram_we    = wr_mem & sel_ram;
    assign push_req  = wr_mem & sel_tx;
    assign status_we = wr_mem & sel_status;
    assign cycle_we  = wr_mem & sel_cycle;

    assign full     = (count_q == CNT_FULL);
    assign empty    = (count_q == '0);
    assign tx_valid = ~empty;
    assign tx_data  = fifo_q[rptr_q];
    assign pop      = tx_valid & tx_ready;
    // A push into a full FIFO still fits when the head leaves in the same cycle.
    assign push_ok  = push_req & (~full | pop);
    assign drop     = push_req & full & ~pop;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        cycle_d = cycle_q + 32'd1;
        if (push_ok) wptr_d = wptr_q + PTR_ONE;
        if (pop)     rptr_d = rptr_q + PTR_ONE;
        if (push_ok && !pop)      count_d = count_q + CNT_ONE;
        else if (pop && !push_ok) count_d = count_q - CNT_ONE;
        if (drop)           ovf_d = 1'b1;
        else if (status_we) ovf_d = 1'b0;
        if (cycle_we) cycle_d = dout;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            cycle_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            cycle_q <= cycle_d;
        end
    end

    // NOTE: storage arrays have no reset; the pointers and count alone define FIFO state.
    always_ff @(posedge clk) begin
        if (ram_we)          ram_q[ram_idx] <= dout;
        if (push_ok && !rst) fifo_q[wptr_q] <= dout;
    end

    always_comb begin
        din = '0;
        if (sel_ram)         din = ram_q[ram_idx];
        else if (sel_status) din = {16'b0, 8'(count_q), 5'b0, ovf_q, full, empty};
        else if (sel_cycle)  din = cycle_q;
    end

endmodule

// File: tb/tb_cpu_dmem_responder.sv
// Bench for cpu_dmem_responder. Directed scenarios and random traffic are checked against a
// queue/array reference model.
module tb_cpu_dmem_responder;
    localparam int RAM_AW = 10;
    localparam int DEPTH  = 8;
    localparam logic [18:0] A_TX = 19'h40000;
    localparam logic [18:0] A_ST = 19'h40004;
    localparam logic [18:0] A_CY = 19'h40008;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_mem = 1'b0;
    logic [18:0] mem_addr = '0;
    logic [31:0] dout = '0;
    logic [31:0] din, tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;

    cpu_dmem_responder #(.RAM_AW(RAM_AW), .FIFO_AW(3)) dut (
        .clk(clk), .rst(rst), .wr_mem(wr_mem), .mem_addr(mem_addr), .dout(dout),
        .din(din), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;
    bit chk_en  = 1'b0;

    bit [31:0]   ram_m [0:(1<<RAM_AW)-1];
    logic [31:0] q_m [$];
    bit          ovf_m;
    bit [31:0]   cyc_m;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit is_reg(input logic [18:0] a, input logic [18:0] r);
        return a[18:2] == r[18:2];
    endfunction

    function automatic logic [31:0] exp_din(input logic [18:0] a);
        int n = q_m.size();
        if (!a[18])          return ram_m[a[11:2]];
        if (is_reg(a, A_ST)) return {16'b0, 8'(n), 5'b0, ovf_m, n == DEPTH, n == 0};
        if (is_reg(a, A_CY)) return cyc_m;
        return 32'h0;
    endfunction

    // Applies one clock edge worth of behaviour to the reference model.
    function automatic void model_step(input bit r, input bit wr, input logic [18:0] a,
                                       input logic [31:0] d, input bit rdy);
        bit full_m, pop_m, push_m;
        if (wr && !a[18]) ram_m[a[11:2]] = d;
        if (r) begin
            q_m.delete();
            ovf_m = 1'b0;
            cyc_m = '0;
            return;
        end
        full_m = (q_m.size() == DEPTH);
        pop_m  = (q_m.size() != 0) && rdy;
        push_m = wr && is_reg(a, A_TX);
        cyc_m  = (wr && is_reg(a, A_CY)) ? d : cyc_m + 32'd1;
        if (wr && is_reg(a, A_ST)) ovf_m = 1'b0;
        if (pop_m) void'(q_m.pop_front());
        if (push_m) begin
            if (full_m && !pop_m) ovf_m = 1'b1;
            else q_m.push_back(d);
        end
    endfunction

    // Drives one cycle, checks outputs before the edge, then advances the model.
    task automatic do_cycle(input bit r, input bit wr, input logic [18:0] a,
                            input logic [31:0] d, input bit rdy, output logic [31:0] obs);
        @(negedge clk);
        rst = r; wr_mem = wr; mem_addr = a; dout = d; tx_ready = rdy;
        #1;
        obs = din;
        if (chk_en) begin
            check("din", din, exp_din(a));
            check("tx_valid", 32'(tx_valid), 32'(q_m.size() != 0));
            if (q_m.size() != 0) check("tx_data", tx_data, q_m[0]);
        end
        model_step(r, wr, a, d, rdy);
    endtask

    function automatic logic [18:0] rand_addr();
        logic [18:0] lo = 19'($urandom_range(0, 3));
        case ($urandom_range(0, 6))
            0, 1, 2: return 19'($urandom_range(0, 31) << 2) | 19'($urandom_range(0, 3) << 12) | lo;
            3:       return A_TX | lo;
            4:       return A_ST | lo;
            5:       return A_CY | lo;
            default: return 19'h40000 | 19'($urandom_range(3, 255) << 2) | lo;
        endcase
    endfunction

    initial begin
        logic [31:0] obs;
        logic [31:0] held;
        bit          prev_rdy;

        do_cycle(1, 0, '0, '0, 0, obs);
        chk_en = 1'b1;

        // Counter after reset release
        for (int i = 0; i < 3; i++) begin
            do_cycle(0, 0, A_CY, '0, 0, obs);
            check("cycle_start", obs, 32'(i));
        end
        do_cycle(0, 1, A_CY, 32'hFFFF_FFFE, 0, obs);
        do_cycle(0, 0, A_CY, '0, 0, obs); check("cycle_load", obs, 32'hFFFF_FFFE);
        do_cycle(0, 0, A_CY, '0, 0, obs); check("cycle_max", obs, 32'hFFFF_FFFF);
        do_cycle(0, 0, A_CY, '0, 0, obs); check("cycle_wrap", obs, 32'h0);

        // RAM round trip, aliasing and read-old on collision
        do_cycle(0, 1, 19'h00010, 32'hDEAD_BEEF, 0, obs);
        do_cycle(0, 1, 19'h00014, 32'h1234_5678, 0, obs);
        do_cycle(0, 0, 19'h00010, '0, 0, obs); check("ram_rd", obs, 32'hDEAD_BEEF);
        do_cycle(0, 0, 19'h00010 + 19'(4 << RAM_AW), '0, 0, obs); check("ram_alias", obs, 32'hDEAD_BEEF);
        do_cycle(0, 1, 19'h00014, 32'hAAAA_AAAA, 0, obs); check("ram_rd_old", obs, 32'h1234_5678);
        do_cycle(0, 0, 19'h00014, '0, 0, obs); check("ram_rd_new", obs, 32'hAAAA_AAAA);

        // Fill past full, clear overflow, then drain
        do_cycle(0, 0, A_ST, '0, 0, obs); check("status_empty", obs, 32'h1);
        for (int i = 1; i <= 9; i++) do_cycle(0, 1, A_TX, 32'(i), 0, obs);
        do_cycle(0, 0, A_ST, '0, 0, obs); check("status_ovf", obs, 32'h0806);
        do_cycle(0, 1, A_ST, 32'h1234, 0, obs);
        do_cycle(0, 0, A_ST, '0, 0, obs); check("status_clr", obs, 32'h0802);
        for (int i = 1; i <= 8; i++) begin
            do_cycle(0, 0, 19'h0, '0, 1, obs);
            check("drain", tx_data, 32'(i));
        end
        do_cycle(0, 0, A_ST, '0, 1, obs);
        check("drained_valid", 32'(tx_valid), 32'h0);
        check("drained_status", obs, 32'h1);

        // Full FIFO with simultaneous push and pop
        for (int i = 0; i < 8; i++) do_cycle(0, 1, A_TX, 32'h100 + 32'(i), 0, obs);
        do_cycle(0, 1, A_TX, 32'h55, 1, obs);
        do_cycle(0, 0, A_ST, '0, 0, obs); check("full_pushpop", obs, 32'h0802);
        for (int i = 1; i <= 8; i++) begin
            do_cycle(0, 0, 19'h0, '0, 1, obs);
            check("pp_order", tx_data, (i == 8) ? 32'h55 : 32'h100 + 32'(i));
        end

        // Backpressure: tx_ready toggles every cycle
        for (int i = 0; i < 6; i++) do_cycle(0, 1, A_TX, 32'hB0 + 32'(i), 0, obs);
        prev_rdy = 1'b1;
        held = '0;
        for (int i = 0; i < 14; i++) begin
            do_cycle(0, 0, 19'h4, '0, i[0], obs);
            if (!prev_rdy && tx_valid) check("bp_hold", tx_data, held);
            prev_rdy = i[0];
            held = tx_data;
        end
        check("bp_done", 32'(tx_valid), 32'h0);

        // Random traffic
        for (int i = 0; i < 600; i++)
            do_cycle($urandom_range(0, 63) == 0, $urandom_range(0, 1) == 1, rand_addr(),
                     $urandom(), $urandom_range(0, 2) != 0, obs);

        // Reset with queued words, a loaded counter and a pending TXDATA write
        do_cycle(1, 0, '0, '0, 0, obs);
        do_cycle(0, 1, 19'h00020, 32'hCAFE_F00D, 0, obs);
        for (int i = 0; i < 5; i++) do_cycle(0, 1, A_TX, 32'hC0 + 32'(i), 0, obs);
        do_cycle(0, 1, A_CY, 32'd100, 0, obs);
        do_cycle(0, 0, A_CY, '0, 0, obs); check("pre_rst_cycle", obs, 32'd100);
        do_cycle(1, 1, A_TX, 32'h77, 0, obs);
        do_cycle(0, 0, A_CY, '0, 0, obs); check("rst_cycle", obs, 32'h0);
        check("rst_valid", 32'(tx_valid), 32'h0);
        do_cycle(0, 0, A_ST, '0, 0, obs); check("rst_status", obs, 32'h1);
        do_cycle(0, 0, 19'h00020, '0, 0, obs); check("rst_ram_kept", obs, 32'hCAFE_F00D);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
